// File: rtl/frs_message_queue.sv
// FRS message queue: capability, status/control and queue-head registers over a
// FIFO of decoded FRS messages, with RW1C status and a one-cycle interrupt pulse.
module frs_message_queue #(
  parameter int QUEUE_DEPTH = 8,
  parameter int FUNC_ID_W   = 16,
  parameter int REASON_W    = 3,
  localparam int CNT_W      = $clog2(QUEUE_DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_valid,
  input  logic [FUNC_ID_W-1:0] msg_func_id,
  input  logic [REASON_W-1:0]  msg_reason,
  input  logic [1:0]           reg_addr,
  input  logic                 reg_wr,
  input  logic [31:0]          reg_wdata,
  input  logic                 reg_rd,
  output logic [31:0]          reg_rdata,
  output logic [CNT_W-1:0]     queue_count,
  output logic                 queue_empty,
  output logic                 frs_irq
);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef struct packed {
    logic [REASON_W-1:0]  reason;
    logic [FUNC_ID_W-1:0] func_id;
  } entry_t;

  entry_t             mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               msg_rcv_q, ovf_q, int_en_q, pend_q;
  logic               wr_ctl, pop, push, drop, pend;
  logic [31:0]        head_word, rdata_d;
  logic               unused_wdata;

  assign unused_wdata = ^{reg_wdata[31:17], reg_wdata[15:2]};

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ctl = reg_wr && (reg_addr == 2'd1);
    pop    = reg_wr && (reg_addr == 2'd2) && (count_q != '0);
    push   = msg_valid && ((count_q < CNT_W'(QUEUE_DEPTH)) || pop);
    drop   = msg_valid && !push;
    pend   = int_en_q & (msg_rcv_q | ovf_q);
    head_word = '0;
    if (count_q != '0) begin
      head_word[FUNC_ID_W-1:0] = mem[rd_ptr].func_id;
      head_word[16 +: REASON_W] = mem[rd_ptr].reason;
    end
    case (reg_addr)
      2'd0:    rdata_d = {20'b0, 12'(QUEUE_DEPTH-1)};
      2'd1:    rdata_d = {15'b0, int_en_q, 14'b0, ovf_q, msg_rcv_q};
      2'd2:    rdata_d = head_word;
      default: rdata_d = '0;
    endcase
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{reason: msg_reason, func_id: msg_func_id};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      msg_rcv_q <= 1'b0;
      ovf_q     <= 1'b0;
      int_en_q  <= 1'b0;
      pend_q    <= 1'b0;
      frs_irq   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      // Hardware set takes priority over a same-cycle W1C.
      msg_rcv_q <= (msg_rcv_q & ~(wr_ctl & reg_wdata[0])) | push;
      ovf_q     <= (ovf_q & ~(wr_ctl & reg_wdata[1])) | drop;
      if (wr_ctl) int_en_q <= reg_wdata[16];
      pend_q  <= pend;
      frs_irq <= pend & ~pend_q;
      if (reg_rd) reg_rdata <= rdata_d;
    end
  end

  assign queue_count = count_q;
  assign queue_empty = (count_q == '0);

endmodule

// File: tb/tb_frs_message_queue.sv
// Directed bench for frs_message_queue (QUEUE_DEPTH=8): register map, FIFO order,
// overflow, simultaneous push/pop, interrupt pulse and async reset.
module tb_frs_message_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid;
  logic [15:0] msg_func_id;
  logic [2:0]  msg_reason;
  logic [1:0]  reg_addr;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic [3:0]  queue_count;
  logic        queue_empty;
  logic        frs_irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  frs_message_queue #(.QUEUE_DEPTH(8), .FUNC_ID_W(16), .REASON_W(3)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_func_id(msg_func_id),
    .msg_reason(msg_reason), .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rd(reg_rd), .reg_rdata(reg_rdata),
    .queue_count(queue_count), .queue_empty(queue_empty), .frs_irq(frs_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    reg_addr = a; reg_rd = 1'b1;
    tick();
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0; reg_wdata = '0;
  endtask

  task automatic push(input logic [15:0] f, input logic [2:0] r);
    msg_func_id = f; msg_reason = r; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    chk("reset_count", 32'(queue_count), 32'd0);
    chk("reset_empty", 32'(queue_empty), 32'd1);
    chk("reset_irq", 32'(frs_irq), 32'd0);
    rd(2'd0, d); chk("cap_reg", d, 32'h0000_0007);
    rd(2'd2, d); chk("empty_head", d, 32'h0);
    rd(2'd1, d); chk("reset_status", d, 32'h0);
    rd(2'd3, d); chk("reserved_reg", d, 32'h0);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    push(16'h0012, 3'd3);
    push(16'h0034, 3'd5);
    chk("basic_count2", 32'(queue_count), 32'd2);
    chk("basic_not_empty", 32'(queue_empty), 32'd0);
    rd(2'd2, d); chk("basic_head0", d, 32'h0003_0012);
    wr(2'd2, 32'h0);
    chk("basic_count1", 32'(queue_count), 32'd1);
    rd(2'd2, d); chk("basic_head1", d, 32'h0005_0034);
    wr(2'd2, 32'h0);
    chk("basic_count0", 32'(queue_count), 32'd0);
    rd(2'd1, d); chk("basic_rcv", d, 32'h0000_0001);
    wr(2'd1, 32'h1);
    wr(2'd2, 32'h0);  // pop while empty
    chk("empty_pop_count", 32'(queue_count), 32'd0);
    rd(2'd1, d); chk("empty_pop_status", d, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 3'(i));
    push(16'h00FF, 3'd1);
    rd(2'd1, d); chk("ovf_status", {30'b0, d[1:0]}, 32'h3);
    chk("ovf_count", 32'(queue_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd(2'd2, d); chk($sformatf("ovf_order%0d", i), d, 32'h0000_0100 + 32'(i) + (32'(i) << 16));
      wr(2'd2, 32'h0);
    end
    chk("ovf_drained", 32'(queue_count), 32'd0);
    rd(2'd2, d); chk("ovf_no_ff", d, 32'h0);
    wr(2'd1, 32'h3);
    rd(2'd1, d); chk("ovf_cleared", d, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) push(16'h0200 + 16'(i), 3'(i));
    wr(2'd1, 32'h1);
    msg_func_id = 16'h02AA; msg_reason = 3'd6; msg_valid = 1'b1;
    wr(2'd2, 32'h0);
    msg_valid = 1'b0;
    chk("b2b_count", 32'(queue_count), 32'd8);
    rd(2'd1, d); chk("b2b_status", d, 32'h0000_0001);
    for (int i = 1; i < 8; i++) begin
      rd(2'd2, d); chk($sformatf("b2b_order%0d", i), d, 32'h0000_0200 + 32'(i) + (32'(i) << 16));
      wr(2'd2, 32'h0);
    end
    rd(2'd2, d); chk("b2b_last", d, 32'h0006_02AA);
    wr(2'd2, 32'h0);
    chk("b2b_empty", 32'(queue_empty), 32'd1);
    wr(2'd1, 32'h3);
  endtask

  task automatic test_irq();
    int hi;
    logic [31:0] d;
    wr(2'd1, 32'h0001_0000);
    rd(2'd1, d); chk("irq_int_en", d, 32'h0001_0000);
    push(16'h0055, 3'd2);
    hi = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (frs_irq) hi++; end
    chk("irq_pulse1", 32'(hi), 32'd1);
    push(16'h0056, 3'd2);
    hi = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (frs_irq) hi++; end
    chk("irq_no_repulse", 32'(hi), 32'd0);
    wr(2'd1, 32'h0001_0001);
    push(16'h0057, 3'd2);
    hi = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (frs_irq) hi++; end
    chk("irq_pulse2", 32'(hi), 32'd1);
    for (int i = 0; i < 3; i++) wr(2'd2, 32'h0);
    chk("irq_drained", 32'(queue_count), 32'd0);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) push(16'h0300 + 16'(i), 3'(i));
    for (int i = 0; i < 3; i++) wr(2'd2, 32'h0);
    chk("pre_rst_count", 32'(queue_count), 32'd5);
    rd(2'd1, d); chk("pre_rst_status", d, 32'h0001_0003);
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_empty", 32'(queue_empty), 32'd1);
    chk("rst_irq", 32'(frs_irq), 32'd0);
    chk("rst_rdata", reg_rdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    rd(2'd1, d); chk("rst_status", d, 32'h0);
    rd(2'd2, d); chk("rst_head", d, 32'h0);
  endtask

  initial begin
    rst = 1'b1; msg_valid = 1'b0; msg_func_id = '0; msg_reason = '0;
    reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0; reg_rd = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_irq();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/frs_message_queue.md
Name: frs_message_queue

Overview:
- Parametrised FRS Queueing block: FRS Queueing Capability, Status/Control and Message Queue registers, plus the message FIFO behind them.
- Accepts decoded FRS messages (function ID and reason) from the receive path and holds them oldest-first.
- Software reads the queue head and pops it through a small register port; overflow and message-received status are RW1C.
- Raises a one-cycle interrupt pulse when enabled status becomes pending.

Parameters:
- QUEUE_DEPTH, 8, number of FIFO entries; legal range 1..4096.
- FUNC_ID_W, 16, function ID width; legal range 1..16.
- REASON_W, 3, FRS reason width; legal range 1..8.
- CNT_W, $clog2(QUEUE_DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- msg_valid  in  1  one FRS message presented this cycle; no backpressure.
- msg_func_id  in  FUNC_ID_W  function ID of the message.
- msg_reason  in  REASON_W  FRS reason code.
- reg_addr  in  2  register select: 0 = capability, 1 = status/control, 2 = message queue, 3 = reserved.
- reg_wr  in  1  register write strobe.
- reg_wdata  in  32  write data.
- reg_rd  in  1  register read strobe.
- reg_rdata  out  32  read data, registered.
- queue_count  out  CNT_W  current occupancy.
- queue_empty  out  1  high when queue_count == 0.
- frs_irq  out  1  one-cycle interrupt pulse.

Behaviour:
- Reset: FIFO empty; queue_count = 0; queue_empty = 1; all status bits, int_en, reg_rdata and frs_irq = 0. Reset mid-operation discards every queued entry immediately.
- Register map, read values:
  - addr 0, RO: [11:0] = QUEUE_DEPTH-1; other bits 0.
  - addr 1, status/control: [0] msg_received (RW1C); [1] overflow (RW1C); [16] int_en (RW); other bits 0.
  - addr 2, message queue: head entry, with [FUNC_ID_W-1:0] = func_id and [16+REASON_W-1:16] = reason. Reads 0 when the queue is empty.
  - addr 3: reads 0; writes ignored.
- Read latency: reg_rdata updates on the clock edge after reg_rd is sampled and holds until the next read. It returns state from before any same-cycle write.
- Write to addr 0: ignored.
- Write to addr 1:
  - wdata[0] = 1 clears msg_received; wdata[1] = 1 clears overflow.
  - int_en <= wdata[16].
- Write to addr 2: any data pops the head entry. Pop while empty has no effect and does not set any status bit.
- Enqueue: on msg_valid, the message is stored at the tail if space exists, and msg_received is set.
- Space exists when queue_count < QUEUE_DEPTH, or when a pop happens in the same cycle.
- Overflow: msg_valid when full with no same-cycle pop:
  - the message is dropped;
  - overflow is set;
  - queue contents and count are unchanged;
  - msg_received is not set.
- Simultaneous push and pop:
  - non-empty: count is unchanged and the head advances;
  - empty: the pop is ignored and the push is accepted (count becomes 1).
- Set vs RW1C clear in the same cycle: set wins.
- Pointers: read and write pointers wrap modulo QUEUE_DEPTH, which need not be a power of two. Order is strictly FIFO.
- Interrupt: pend = int_en & (msg_received | overflow). frs_irq = 1 for exactly one cycle on the 0->1 edge of registered pend. No re-pulse while pend stays high.
- queue_count and queue_empty are registered and reflect the state after the current edge.

Test Plan:
- Reset, then read addr 0 with QUEUE_DEPTH=8 -> reg_rdata = 0x0000_0007. Read addr 2 -> 0. queue_empty = 1.
- Enqueue (0x0012, 3), (0x0034, 5); read addr 2 -> 0x0003_0012; write addr 2; read addr 2 -> 0x0005_0034; queue_count goes 2 -> 1.
- Fill 8 entries, send a 9th message (0x00FF, 1):
  - read addr 1 -> bits[1:0] = 2'b11;
  - queue_count = 8;
  - pop all 8 -> original order, and 0x00FF is never seen.
  - Write addr 1 with 0x3 -> status reads 0.
- Full queue, msg_valid and pop in the same cycle -> count stays 8, new entry is last out, overflow stays 0.
- Write int_en = 1 (0x0001_0000), then enqueue one message -> frs_irq high for exactly 1 cycle.
  - Enqueue another without clearing status -> no pulse.
  - Clear with 0x0001_0001, then enqueue -> new pulse.
- Assert rst with 5 entries queued and overflow set -> next cycle count = 0, status = 0, int_en = 0, frs_irq = 0.
